// File: rtl/ram_ctl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_ctl_if : request / clear / response bus for ram_ctl            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ram_ctl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              inj_perr;
  logic              clr;
  logic              busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, inj_perr, clr,
    input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, inj_perr, clr,
    output req_ready, busy, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_ctl : single-port RAM controller with clear engine and          |
// |           READ_LAT 1/2 read pipeline; parity under RAM_PARITY_EN    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ram_ctl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 9,
  parameter int READ_LAT = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  ram_ctl_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              xfer;
  logic              rd_xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              s1_valid_q;
  logic [MEM_W-1:0]  s1_word_q;
  logic              tail_valid;
  logic [MEM_W-1:0]  tail_word;
  logic              tail_err;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign xfer    = bus.req_valid && (state_q == ST_RUN);
  assign rd_xfer = xfer && !bus.req_we;

  assign bus.req_ready = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_d = ST_RUN;
      end
    end else if (bus.clr) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  // Clear writes all-zero words, whose even parity bit is also zero.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_word = '0;
    if (state_q == ST_CLEAR) begin
      wr_en = 1'b1;
    end else if (xfer && bus.req_we) begin
      wr_en   = 1'b1;
      wr_addr = bus.req_addr;
`ifdef RAM_PARITY_EN
      wr_word = {(^bus.req_wdata) ^ bus.inj_perr, bus.req_wdata};
`else
      wr_word = bus.req_wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
    if (rd_xfer) begin
      s1_word_q <= mem[bus.req_addr];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             s2_valid_q;
      logic [MEM_W-1:0] s2_word_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
        end
      end

      always_ff @(posedge clk) begin
        if (s1_valid_q) begin
          s2_word_q <= s1_word_q;
        end
      end

      assign tail_valid = s2_valid_q;
      assign tail_word  = s2_word_q;
    end else begin : g_lat1
      assign tail_valid = s1_valid_q;
      assign tail_word  = s1_word_q;
    end
  endgenerate

`ifdef RAM_PARITY_EN
  assign tail_err = ^tail_word;
`else
  logic unused_inj_perr;
  assign unused_inj_perr = bus.inj_perr;
  assign tail_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= rd_xfer;
      rsp_valid_q <= tail_valid;
      if (tail_valid) begin
        rsp_rdata_q <= tail_word[DATA_W-1:0];
        rsp_err_q   <= tail_err;
      end
    end
  end
endmodule
`default_nettype wire
